// File: rtl/snake_game_pkg.sv
// Shared types, defaults and helpers for the two-snake game sequencer.
package snake_game_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PLAY  = 2'd1,
        ST_PAUSE = 2'd2,
        ST_OVER  = 2'd3
    } game_state_t;

    typedef enum logic [1:0] {
        CAUSE_NONE = 2'd0,
        CAUSE_WALL = 2'd1,
        CAUSE_HEAD = 2'd2
    } over_cause_t;

    // USB HID usage codes: space starts/restarts, 'P' toggles pause.
    localparam logic [7:0] KEY_START_DEF = 8'h2C;
    localparam logic [7:0] KEY_PAUSE_DEF = 8'h13;

    // Visible screen area in pixels.
    localparam int unsigned SCR_W_DEF = 640;
    localparam int unsigned SCR_H_DEF = 480;

    // Largest four-digit BCD value; the score sticks here.
    localparam logic [15:0] BCD_MAX = 16'h9999;

    // Absolute difference of two 10-bit coordinates, widened to 11 bits so
    // it compares directly against a doubled head size.
    function automatic logic [10:0] abs_diff11(input logic [9:0] a, input logic [9:0] b);
        logic [10:0] ea;
        logic [10:0] eb;
        ea = {1'b0, a};
        eb = {1'b0, b};
        return (ea >= eb) ? (ea - eb) : (eb - ea);
    endfunction

endpackage

// File: rtl/snake_game_ctrl_bcd_counter4.sv
// Four-digit BCD up-counter with synchronous clear and saturation at 9999.
module bcd_counter4
    import snake_game_pkg::*;
(
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        inc_i,
    input  logic        clr_i,
    output logic [15:0] bcd_o
);

    logic [15:0] bcd_q;
    logic [15:0] bcd_d;
    logic        carry;

    // Next count: clear wins, otherwise ripple +1 through the digits unless saturated.
    always_comb begin
        // NOTE: every signal driven here gets a default first so no latch is inferred.
        bcd_d = bcd_q;
        carry = 1'b0;
        if (clr_i) begin
            bcd_d = '0;
        end else if (inc_i && (bcd_q != BCD_MAX)) begin
            carry = 1'b1;
            for (int i = 0; i < 4; i++) begin
                if (carry) begin
                    if (bcd_q[4*i +: 4] == 4'd9) begin
                        bcd_d[4*i +: 4] = 4'd0;
                    end else begin
                        bcd_d[4*i +: 4] = bcd_q[4*i +: 4] + 4'd1;
                        carry           = 1'b0;
                    end
                end
            end
        end
    end

    // Count register.
    always_ff @(posedge Clk or negedge Reset_n) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (!Reset_n) begin
            bcd_q <= '0;
        end else begin
            bcd_q <= bcd_d;
        end
    end

    assign bcd_o = bcd_q;

endmodule

// File: rtl/snake_game_ctrl.sv
// Game sequencer: frame/step strobes from vsync, IDLE/PLAY/PAUSE/OVER flow
// from keyboard presses, wall/head collision detection and BCD scoring.
module snake_game_ctrl
    import snake_game_pkg::*;
#(
    parameter int unsigned STEP_FRAMES = 4,
    parameter int unsigned OVER_FRAMES = 60,
    parameter logic [7:0]  KEY_START   = KEY_START_DEF,
    parameter logic [7:0]  KEY_PAUSE   = KEY_PAUSE_DEF,
    parameter int unsigned SCR_W       = SCR_W_DEF,
    parameter int unsigned SCR_H       = SCR_H_DEF
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        vs,
    input  logic [15:0] keycode,
    input  logic [9:0]  s1_x,
    input  logic [9:0]  s1_y,
    input  logic [9:0]  s2_x,
    input  logic [9:0]  s2_y,
    input  logic [9:0]  s_size,
    output logic [1:0]  game_state,
    output logic        snake_run,
    output logic        snake_clr,
    output logic        frame_tick,
    output logic        step_strobe,
    output logic [1:0]  over_cause,
    output logic [15:0] score_bcd,
    output logic [15:0] hi_bcd
);

    localparam logic [3:0]          STEP_LAST = 4'(STEP_FRAMES - 1);
    localparam int unsigned         OVER_W    = $clog2(OVER_FRAMES + 1);
    localparam logic [OVER_W-1:0]   OVER_MAX  = OVER_W'(OVER_FRAMES);
    localparam logic [10:0]         X_LIMIT   = 11'(SCR_W - 1);
    localparam logic [10:0]         Y_LIMIT   = 11'(SCR_H - 1);

    // vsync synchroniser and edge detector
    logic vs_meta_q;
    logic vs_sync_q;
    logic vs_prev_q;
    logic frame_tick_q;

    // key held flags
    logic start_held_q;
    logic pause_held_q;
    logic start_present;
    logic pause_present;
    logic start_press;
    logic pause_press;

    // dividers
    logic [3:0]        step_cnt_q;
    logic [3:0]        step_cnt_d;
    logic              step_strobe_q;
    logic              step_strobe_d;
    logic [OVER_W-1:0] over_cnt_q;
    logic [OVER_W-1:0] over_cnt_d;

    // FSM and registered outputs
    game_state_t state_q;
    game_state_t state_d;
    logic        snake_run_q;
    logic        snake_run_d;
    logic        snake_clr_q;
    logic        snake_clr_d;
    over_cause_t cause_q;
    over_cause_t cause_d;
    logic [15:0] hi_q;
    logic [15:0] hi_d;
    logic        score_clr;

    // collision terms
    logic [10:0] size11;
    logic [10:0] size2x;
    logic        wall_hit;
    logic        head_hit;
    logic [15:0] score_q;

    // Two-flop vsync synchroniser followed by a registered falling-edge strobe.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            vs_meta_q    <= 1'b1;
            vs_sync_q    <= 1'b1;
            vs_prev_q    <= 1'b1;
            frame_tick_q <= 1'b0;
        end else begin
            vs_meta_q    <= vs;
            vs_sync_q    <= vs_meta_q;
            vs_prev_q    <= vs_sync_q;
            frame_tick_q <= vs_prev_q & ~vs_sync_q;
        end
    end

    // A key counts as present when either HID slot carries its code.
    assign start_present = (keycode[7:0] == KEY_START) || (keycode[15:8] == KEY_START);
    assign pause_present = (keycode[7:0] == KEY_PAUSE) || (keycode[15:8] == KEY_PAUSE);
    assign start_press   = start_present & ~start_held_q;
    assign pause_press   = pause_present & ~pause_held_q;

    // Held flags, so a key kept down yields one press only.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            start_held_q <= 1'b0;
            pause_held_q <= 1'b0;
        end else begin
            start_held_q <= start_present;
            pause_held_q <= pause_present;
        end
    end

    // Wall and head-to-head tests on 11-bit sums so nothing wraps.
    always_comb begin
        size11   = {1'b0, s_size};
        size2x   = {s_size, 1'b0};
        wall_hit = ({1'b0, s1_x} < size11) || (({1'b0, s1_x} + size11) > X_LIMIT) ||
                   ({1'b0, s1_y} < size11) || (({1'b0, s1_y} + size11) > Y_LIMIT) ||
                   ({1'b0, s2_x} < size11) || (({1'b0, s2_x} + size11) > X_LIMIT) ||
                   ({1'b0, s2_y} < size11) || (({1'b0, s2_y} + size11) > Y_LIMIT);
        head_hit = (abs_diff11(s1_x, s2_x) < size2x) && (abs_diff11(s1_y, s2_y) < size2x);
    end

    // Step divider: counts frames in PLAY, frozen in PAUSE, cleared elsewhere.
    always_comb begin
        step_cnt_d    = step_cnt_q;
        step_strobe_d = 1'b0;
        case (state_q)
            ST_PLAY: begin
                if (frame_tick_q) begin
                    if (step_cnt_q == STEP_LAST) begin
                        step_strobe_d = 1'b1;
                        step_cnt_d    = '0;
                    end else begin
                        step_cnt_d = step_cnt_q + 4'd1;
                    end
                end
            end
            ST_PAUSE: step_cnt_d = step_cnt_q;
            default:  step_cnt_d = '0;
        endcase
    end

    // OVER dwell counter: counts frames while in OVER and sticks at the limit.
    always_comb begin
        over_cnt_d = '0;
        if (state_q == ST_OVER) begin
            over_cnt_d = over_cnt_q;
            if (frame_tick_q && (over_cnt_q != OVER_MAX)) begin
                over_cnt_d = over_cnt_q + 1'b1;
            end
        end
    end

    // Divider registers.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            step_cnt_q    <= '0;
            step_strobe_q <= 1'b0;
            over_cnt_q    <= '0;
        end else begin
            step_cnt_q    <= step_cnt_d;
            step_strobe_q <= step_strobe_d;
            over_cnt_q    <= over_cnt_d;
        end
    end

    // Game flow: next state plus the outputs that change on transitions.
    always_comb begin
        state_d     = state_q;
        snake_clr_d = 1'b0;
        cause_d     = cause_q;
        hi_d        = hi_q;
        score_clr   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_press) begin
                    state_d     = ST_PLAY;
                    snake_clr_d = 1'b1;
                    cause_d     = CAUSE_NONE;
                    score_clr   = 1'b1;
                end
            end
            ST_PLAY: begin
                // A collision on this frame ends the game even if pause was pressed.
                if (frame_tick_q && (wall_hit || head_hit)) begin
                    state_d = ST_OVER;
                    cause_d = wall_hit ? CAUSE_WALL : CAUSE_HEAD;
                    if (score_q > hi_q) begin
                        hi_d = score_q;
                    end
                end else if (pause_press) begin
                    state_d = ST_PAUSE;
                end
            end
            ST_PAUSE: begin
                if (pause_press) begin
                    state_d = ST_PLAY;
                end
            end
            ST_OVER: begin
                // Early start presses are swallowed by the held flag.
                if (start_press && (over_cnt_q == OVER_MAX)) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        snake_run_d = (state_d == ST_PLAY);
    end

    // FSM state and registered outputs.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q     <= ST_IDLE;
            snake_run_q <= 1'b0;
            snake_clr_q <= 1'b0;
            cause_q     <= CAUSE_NONE;
            hi_q        <= '0;
        end else begin
            state_q     <= state_d;
            snake_run_q <= snake_run_d;
            snake_clr_q <= snake_clr_d;
            cause_q     <= cause_d;
            hi_q        <= hi_d;
        end
    end

    bcd_counter4 u_score (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .inc_i   (step_strobe_q),
        .clr_i   (score_clr),
        .bcd_o   (score_q)
    );

    assign game_state  = state_q;
    assign snake_run   = snake_run_q;
    assign snake_clr   = snake_clr_q;
    assign frame_tick  = frame_tick_q;
    assign step_strobe = step_strobe_q;
    assign over_cause  = cause_q;
    assign score_bcd   = score_q;
    assign hi_bcd      = hi_q;

endmodule

// File: tb/tb_snake_game_ctrl.sv
// Scoreboard bench for snake_game_ctrl with a frame-level behavioural model.
module tb_snake_game_ctrl;

    localparam int SF = 4;
    localparam int OF = 60;
    localparam int W  = 640;
    localparam int H  = 480;

    logic        Clk = 1'b0;
    logic        Reset_n = 1'b0;
    logic        vs = 1'b1;
    logic [15:0] keycode = '0;
    logic [9:0]  s1_x = 10'd100, s1_y = 10'd100, s2_x = 10'd400, s2_y = 10'd300, s_size = 10'd4;
    logic [1:0]  game_state;
    logic        snake_run, snake_clr, frame_tick, step_strobe;
    logic [1:0]  over_cause;
    logic [15:0] score_bcd, hi_bcd;

    logic        bcd_inc = 1'b0, bcd_clr = 1'b0;
    logic [15:0] bcd_out;

    snake_game_ctrl dut (
        .Clk(Clk), .Reset_n(Reset_n), .vs(vs), .keycode(keycode),
        .s1_x(s1_x), .s1_y(s1_y), .s2_x(s2_x), .s2_y(s2_y), .s_size(s_size),
        .game_state(game_state), .snake_run(snake_run), .snake_clr(snake_clr),
        .frame_tick(frame_tick), .step_strobe(step_strobe), .over_cause(over_cause),
        .score_bcd(score_bcd), .hi_bcd(hi_bcd)
    );

    bcd_counter4 u_bcd (
        .Clk(Clk), .Reset_n(Reset_n), .inc_i(bcd_inc), .clr_i(bcd_clr), .bcd_o(bcd_out)
    );

    always #5 Clk = ~Clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int to_bcd(input int v);
        return (((v / 1000) % 10) << 12) | (((v / 100) % 10) << 8) | (((v / 10) % 10) << 4) | (v % 10);
    endfunction

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    // Model: 0 idle, 1 play, 2 pause, 3 over. Score held as an integer.
    int m_st = 0, m_score = 0, m_hi = 0, m_cause = 0, m_step_cnt = 0, m_over_cnt = 0, m_clr = 0;

    typedef struct {
        int st;
        int score;
        int cause;
        int hi;
        bit step;
    } exp_t;
    exp_t exp_q[$];

    // Monitor counters and state
    bit mon_en = 1'b0;
    int tick_cnt = 0, clr_cnt = 0, strobe_cnt = 0;

    initial begin : monitor
        bit step_due;
        bit step_exp;
        bit prev_tick;
        exp_t e;
        step_due  = 1'b0;
        step_exp  = 1'b0;
        prev_tick = 1'b0;
        forever begin
            @(negedge Clk);
            if (mon_en) begin
                if (step_strobe) strobe_cnt++;
                if (snake_clr) clr_cnt++;
                if (step_due) begin
                    check("step_strobe after tick", step_strobe, step_exp);
                    step_due = 1'b0;
                end else if (step_strobe) begin
                    check("step_strobe without tick", step_strobe, 0);
                end
                if (prev_tick) check("frame_tick width", frame_tick, 0);
                if (frame_tick && !prev_tick) begin
                    tick_cnt++;
                    if (exp_q.size() == 0) begin
                        check("unexpected frame_tick", frame_tick, 0);
                    end else begin
                        e = exp_q.pop_front();
                        check("game_state", game_state, e.st);
                        check("snake_run", snake_run, (e.st == 1) ? 1 : 0);
                        check("score_bcd", score_bcd, to_bcd(e.score));
                        check("over_cause", over_cause, e.cause);
                        check("hi_bcd", hi_bcd, to_bcd(e.hi));
                        step_due = 1'b1;
                        step_exp = e.step;
                    end
                end
                prev_tick = frame_tick;
            end else begin
                step_due  = 1'b0;
                prev_tick = 1'b0;
            end
        end
    end

    // Apply one key event to the model.
    task automatic model_key(input logic [15:0] code);
        bit st, pa;
        st = (code[7:0] == 8'h2C) || (code[15:8] == 8'h2C);
        pa = (code[7:0] == 8'h13) || (code[15:8] == 8'h13);
        case (m_st)
            0: if (st) begin m_st = 1; m_score = 0; m_cause = 0; m_step_cnt = 0; m_clr++; end
            1: if (pa) m_st = 2;
            2: if (pa) m_st = 1;
            default: if (st && m_over_cnt == OF) m_st = 0;
        endcase
    endtask

    // Apply one frame to the model, pushing what the DUT should show before it.
    task automatic model_frame(input int x1, input int y1, input int x2, input int y2, input int sz);
        exp_t e;
        bit wall, head, step;
        step    = (m_st == 1) && (m_step_cnt == SF - 1);
        e.st    = m_st;
        e.score = m_score;
        e.cause = m_cause;
        e.hi    = m_hi;
        e.step  = step;
        exp_q.push_back(e);
        if (m_st == 1) begin
            wall = (x1 < sz) || (x1 + sz > W - 1) || (y1 < sz) || (y1 + sz > H - 1) ||
                   (x2 < sz) || (x2 + sz > W - 1) || (y2 < sz) || (y2 + sz > H - 1);
            head = (iabs(x1 - x2) < 2 * sz) && (iabs(y1 - y2) < 2 * sz);
            m_step_cnt = step ? 0 : m_step_cnt + 1;
            if (wall || head) begin
                if (m_score > m_hi) m_hi = m_score;
                m_cause    = wall ? 1 : 2;
                m_st       = 3;
                m_over_cnt = 0;
                m_step_cnt = 0;
            end
            if (step && m_score < 9999) m_score++;
        end else if (m_st == 3) begin
            if (m_over_cnt < OF) m_over_cnt++;
        end
    endtask

    task automatic do_frame(input int x1, input int y1, input int x2, input int y2, input int sz);
        s1_x = 10'(x1); s1_y = 10'(y1); s2_x = 10'(x2); s2_y = 10'(y2); s_size = 10'(sz);
        model_frame(x1, y1, x2, y2, sz);
        vs = 1'b0;
        repeat (2) @(negedge Clk);
        check("frame_tick early", frame_tick, 0);
        @(negedge Clk);
        check("frame_tick latency", frame_tick, 1);
        vs = 1'b1;
        repeat (5) @(negedge Clk);
    endtask

    task automatic safe_frames(input int n);
        for (int i = 0; i < n; i++) do_frame(150, 150, 400, 300, 8);
    endtask

    task automatic press_key(input logic [15:0] code, input int hold);
        model_key(code);
        keycode = code;
        repeat (hold) @(negedge Clk);
        keycode = '0;
        repeat (3) @(negedge Clk);
    endtask

    // Bring the game back to PLAY from wherever it is.
    task automatic goto_play();
        if (m_st == 3) begin
            while (m_over_cnt < OF) safe_frames(1);
            press_key(16'h002C, 4);
        end
        if (m_st == 2) press_key(16'h1300, 4);
        if (m_st == 0) press_key(16'h002C, 4);
    endtask

    task automatic check_outputs_vs_model(input string tag);
        check({tag, " state"}, game_state, m_st);
        check({tag, " score"}, score_bcd, to_bcd(m_score));
        check({tag, " cause"}, over_cause, m_cause);
        check({tag, " hi"}, hi_bcd, to_bcd(m_hi));
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        logic [15:0] codes [4];
        int m_b;
        codes[0] = 16'h002C; codes[1] = 16'h1300; codes[2] = 16'h132C; codes[3] = 16'h0404;

        // Reset state
        repeat (3) @(negedge Clk);
        check("reset game_state", game_state, 0);
        check("reset snake_run", snake_run, 0);
        check("reset snake_clr", snake_clr, 0);
        check("reset frame_tick", frame_tick, 0);
        check("reset step_strobe", step_strobe, 0);
        check("reset over_cause", over_cause, 0);
        check("reset score_bcd", score_bcd, 0);
        check("reset hi_bcd", hi_bcd, 0);
        Reset_n = 1'b1;
        mon_en  = 1'b1;
        repeat (2) @(negedge Clk);

        // Three idle frames
        safe_frames(3);
        check("idle tick count", tick_cnt, 3);
        check("idle strobe count", strobe_cnt, 0);

        // Start held 10 cycles
        press_key(16'h002C, 10);
        check("start clr pulses", clr_cnt, m_clr);
        check("start state", game_state, 1);
        safe_frames(8);
        check("two steps score", score_bcd, 16'h0002);

        // Pause, frames, resume
        press_key(16'h1300, 6);
        check("paused state", game_state, 2);
        safe_frames(8);
        check("paused score", score_bcd, to_bcd(m_score));
        press_key(16'h1300, 6);
        check("resumed state", game_state, 1);
        check("resume no clr", clr_cnt, m_clr);
        safe_frames(5);

        // Wall hit
        do_frame(3, 100, 400, 300, 4);
        repeat (2) @(negedge Clk);
        check_outputs_vs_model("wall");
        check("wall cause", over_cause, 1);

        // OVER dwell: early start ignored, start at limit accepted
        safe_frames(10);
        press_key(16'h002C, 4);
        check("early start ignored", game_state, 3);
        safe_frames(50);
        press_key(16'h002C, 4);
        check("start after dwell", game_state, 0);

        // Wall and head on the same frame: wall wins
        press_key(16'h002C, 4);
        check("restart cause cleared", over_cause, 0);
        safe_frames(6);
        do_frame(3, 100, 6, 100, 4);
        repeat (2) @(negedge Clk);
        check("wall beats head", over_cause, 1);

        // Head collision boundary
        goto_play();
        safe_frames(2);
        do_frame(100, 100, 108, 100, 4);
        check("touching heads stay", game_state, 1);
        do_frame(100, 100, 107, 100, 4);
        repeat (2) @(negedge Clk);
        check("head cause", over_cause, 2);
        check_outputs_vs_model("head");

        // Randomised play
        for (int i = 0; i < 500; i++) begin
            int r;
            r = int'($urandom_range(0, 99));
            if (r < 70) begin
                if ($urandom_range(0, 99) < 85)
                    do_frame(int'($urandom_range(60, 200)), int'($urandom_range(60, 200)),
                             int'($urandom_range(300, 560)), int'($urandom_range(250, 400)),
                             int'($urandom_range(1, 40)));
                else
                    do_frame(int'($urandom_range(0, 639)), int'($urandom_range(0, 479)),
                             int'($urandom_range(0, 639)), int'($urandom_range(0, 479)),
                             int'($urandom_range(1, 40)));
            end else begin
                press_key(codes[$urandom_range(0, 3)], int'($urandom_range(1, 6)));
            end
        end
        check_outputs_vs_model("random end");

        // Reset mid-PLAY
        goto_play();
        safe_frames(5);
        check("pre-reset state", game_state, 1);
        mon_en  = 1'b0;
        Reset_n = 1'b0;
        #1;
        check("async reset game_state", game_state, 0);
        check("async reset snake_run", snake_run, 0);
        check("async reset over_cause", over_cause, 0);
        check("async reset score_bcd", score_bcd, 0);
        check("async reset hi_bcd", hi_bcd, 0);
        check("async reset step_strobe", step_strobe, 0);
        m_st = 0; m_score = 0; m_hi = 0; m_cause = 0; m_step_cnt = 0; m_over_cnt = 0;
        repeat (2) @(negedge Clk);
        Reset_n = 1'b1;
        mon_en  = 1'b1;
        repeat (2) @(negedge Clk);
        safe_frames(2);

        // Standalone BCD counter: carries and saturation
        bcd_clr = 1'b1;
        @(negedge Clk);
        bcd_clr = 1'b0;
        m_b = 0;
        check("bcd cleared", bcd_out, 0);
        for (int i = 1; i <= 10000; i++) begin
            bcd_inc = 1'b1;
            @(negedge Clk);
            if (m_b < 9999) m_b++;
            if (i == 9 || i == 10 || i == 99 || i == 100 || i == 1000 || i == 5678 ||
                i == 9999 || i == 10000)
                check("bcd count", bcd_out, to_bcd(m_b));
        end
        bcd_clr = 1'b1;
        @(negedge Clk);
        bcd_inc = 1'b0;
        bcd_clr = 1'b0;
        check("bcd clr beats inc", bcd_out, 0);

        check("pending expectations", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
